mano_sequencer: RTL and testbench

Timing and instruction-decode front end for the basic-computer control unit. Holds the sequence counter (SC), instruction register (IR), and run flip-flop (S). Drives the one-hot timing vector T, the decoded opcode D, the indirect bit I and the register-reference bit vector B. It consumes the control unit's LDIR and CLRSC strobes, closing the fetch/decode/execute loop.

---
 rtl/mano_pkg.sv | 35 +++
 rtl/mano_seq_counter.sv | 29 ++
 rtl/mano_sequencer.sv | 90 +++++++++
 tb/tb_mano_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared constants, state type and decode helper for the basic-computer sequencer.
package mano_pkg;

  localparam int IR_W_DEFAULT = 16;
  localparam int SC_W_DEFAULT = 3;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam int B_INC = 0;
  localparam int B_CIL = 1;
  localparam int B_CMA = 2;
  localparam int B_CLA = 3;
  localparam int B_CLE = 4;
  localparam int B_CME = 5;
  localparam int B_CIR = 6;
  localparam int B_HLT = 7;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } run_state_t;

  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    onehot8 = 8'h01 << sel;
  endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter SC with enable/clear and its one-hot timing decoder T.
module mano_seq_counter #(
  parameter int SC_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  output logic [2**SC_W-1:0]   t
);

  localparam logic [SC_W-1:0]   SC_ONE = 1;
  localparam logic [2**SC_W-1:0] T_ONE = 1;

  logic [SC_W-1:0] sc;

  // Counter free-wraps; clear only takes effect while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc <= '0;
    end else if (en) begin
      if (clr) sc <= '0;
      else     sc <= sc + SC_ONE;
    end
  end

  assign t = en ? (T_ONE << sc) : '0;

endmodule

// File: rtl/mano_sequencer.sv
// Timing/decode front end: holds IR and the run flag, drives T, D, I, B.
// Optional macro MANO_SINGLE_STEP_EN adds a step input that runs one instruction.
//
// state   | meaning
// ST_HALT | S=0, SC frozen, T all zero
// ST_RUN  | S=1, free running
// ST_STEP | S=1, stop at the next sc_clr (single-step build only)
module mano_sequencer
  import mano_pkg::*;
#(
  parameter int IR_W = mano_pkg::IR_W_DEFAULT,
  parameter int SC_W = mano_pkg::SC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ir_ld,
  input  logic               sc_clr,
`ifdef MANO_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [IR_W-1:0]    bus_in,
  output logic [2**SC_W-1:0] T,
  output logic [7:0]         D,
  output logic               I,
  output logic [7:0]         B,
  output logic               halted,
  output logic [IR_W-1:0]    ir_q
);

  run_state_t      state;
  logic [IR_W-1:0] ir;
  logic            s_run;
  logic            hlt;

  assign s_run = (state != ST_HALT);
  assign hlt   = D[OP_REG] & ~I & T[3] & ir[0];

  // HLT shares the counter clear so SC lands on 0 together with S=0.
  mano_seq_counter #(.SC_W(SC_W)) u_sc (
    .clk (clk),
    .rst (rst),
    .en  (s_run),
    .clr (sc_clr | hlt),
    .t   (T)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HALT;
      ir    <= '0;
    end else begin
      if (ir_ld && s_run) ir <= bus_in;
      case (state)
        ST_HALT: begin
          if (start) state <= ST_RUN;
`ifdef MANO_SINGLE_STEP_EN
          else if (step) state <= ST_STEP;
`endif
        end
        ST_RUN: begin
          if (hlt) state <= ST_HALT;
        end
`ifdef MANO_SINGLE_STEP_EN
        ST_STEP: begin
          if (hlt)         state <= ST_HALT;
          else if (start)  state <= ST_RUN;
          else if (sc_clr) state <= ST_HALT;
        end
`endif
        default: state <= ST_HALT;
      endcase
    end
  end

  assign D      = onehot8(ir[14:12]);
  assign I      = ir[IR_W-1];
  assign halted = ~s_run;
  assign ir_q   = ir;

  assign B[B_INC] = ir[5];
  assign B[B_CIL] = ir[6];
  assign B[B_CMA] = ir[9];
  assign B[B_CLA] = ir[11];
  assign B[B_CLE] = ir[10];
  assign B[B_CME] = ir[8];
  assign B[B_CIR] = ir[7];
  assign B[B_HLT] = ir[0];

endmodule

// File: tb/tb_mano_sequencer.sv
// Directed self-checking bench for mano_sequencer (inputs driven and outputs sampled on the falling edge).
module tb_mano_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, ir_ld, sc_clr;
`ifdef MANO_SINGLE_STEP_EN
  logic        step;
`endif
  logic [15:0] bus_in;
  logic [7:0]  T, D, B;
  logic        I, halted;
  logic [15:0] ir_q;

  int n_cmp = 0;
  int n_err = 0;

  mano_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ir_ld  (ir_ld),
    .sc_clr (sc_clr),
`ifdef MANO_SINGLE_STEP_EN
    .step   (step),
`endif
    .bus_in (bus_in),
    .T      (T),
    .D      (D),
    .I      (I),
    .B      (B),
    .halted (halted),
    .ir_q   (ir_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task test_reset;
    rst = 1'b1; start = 1'b1; ir_ld = 1'b1; sc_clr = 1'b0; bus_in = 16'hFFFF;
`ifdef MANO_SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({T, D, I, B, halted, ir_q} !== {8'h00, 8'h01, 1'b0, 8'h00, 1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_state: T=%h D=%h I=%b B=%h halted=%b ir_q=%h want 00 01 0 00 1 0000",
               T, D, I, B, halted, ir_q);
    end
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sc_clr = k[0];
      @(negedge clk);
      n_cmp++;
      if ({T, D, halted, ir_q} !== {8'h00, 8'h01, 1'b1, 16'h0000}) begin
        n_err++;
        $display("FAIL idle_%0d: T=%h D=%h halted=%b ir_q=%h want 00 01 1 0000", k, T, D, halted, ir_q);
      end
    end
    ir_ld = 1'b0; sc_clr = 1'b0; bus_in = 16'h0000;
  endtask

  task test_fetch_decode;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if ({T, halted} !== {8'h01, 1'b0}) begin
      n_err++; $display("FAIL fd_t0: T=%h halted=%b want 01 0", T, halted);
    end
    @(negedge clk);
    n_cmp++;
    if (T !== 8'h02) begin n_err++; $display("FAIL fd_t1: T=%h want 02", T); end
    ir_ld = 1'b1; bus_in = 16'h7020;
    @(negedge clk); ir_ld = 1'b0;
    n_cmp++;
    if ({T, D, I, B} !== {8'h04, 8'h80, 1'b0, 8'h01}) begin
      n_err++; $display("FAIL fd_t2_decode: T=%h D=%h I=%b B=%h want 04 80 0 01", T, D, I, B);
    end
    @(negedge clk);
    n_cmp++;
    if (T !== 8'h08) begin n_err++; $display("FAIL fd_t3: T=%h want 08", T); end
    sc_clr = 1'b1;
    @(negedge clk); sc_clr = 1'b0;
    n_cmp++;
    if ({T, halted} !== {8'h01, 1'b0}) begin
      n_err++; $display("FAIL fd_clr_t0: T=%h halted=%b want 01 0", T, halted);
    end
  endtask

  task test_halt;
    @(negedge clk);
    ir_ld = 1'b1; bus_in = 16'h7001;
    @(negedge clk); ir_ld = 1'b0;
    n_cmp++;
    if ({T, D, I, B} !== {8'h04, 8'h80, 1'b0, 8'h80}) begin
      n_err++; $display("FAIL hlt_t2_decode: T=%h D=%h I=%b B=%h want 04 80 0 80", T, D, I, B);
    end
    @(negedge clk);
    n_cmp++;
    if ({T, halted} !== {8'h08, 1'b0}) begin
      n_err++; $display("FAIL hlt_t3: T=%h halted=%b want 08 0", T, halted);
    end
    @(negedge clk);
    n_cmp++;
    if ({T, halted, ir_q} !== {8'h00, 1'b1, 16'h7001}) begin
      n_err++; $display("FAIL hlt_stopped: T=%h halted=%b ir_q=%h want 00 1 7001", T, halted, ir_q);
    end
    @(negedge clk);
    n_cmp++;
    if ({T, halted} !== {8'h00, 1'b1}) begin
      n_err++; $display("FAIL hlt_stays: T=%h halted=%b want 00 1", T, halted);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if ({T, halted} !== {8'h01, 1'b0}) begin
      n_err++; $display("FAIL hlt_restart: T=%h halted=%b want 01 0", T, halted);
    end
  endtask

  task test_wrap;
    logic [7:0] exp_t [8];
    exp_t = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    @(negedge clk);
    ir_ld = 1'b1; bus_in = 16'h9123;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); ir_ld = 1'b0;
      n_cmp++;
      if (T !== exp_t[k]) begin
        n_err++; $display("FAIL wrap_step_%0d: T=%h want %h", k, T, exp_t[k]);
      end
      if (k == 0) begin
        n_cmp++;
        if ({D, I, B} !== {8'h02, 1'b1, 8'hA1}) begin
          n_err++; $display("FAIL wrap_decode: D=%h I=%b B=%h want 02 1 a1", D, I, B);
        end
      end
    end
  endtask

  task test_hlt_priority;
    ir_ld = 1'b1; bus_in = 16'h7001;
    @(negedge clk); ir_ld = 1'b0;
    n_cmp++;
    if (T !== 8'h04) begin n_err++; $display("FAIL prio_t2: T=%h want 04", T); end
    @(negedge clk);
    n_cmp++;
    if (T !== 8'h08) begin n_err++; $display("FAIL prio_t3: T=%h want 08", T); end
    start = 1'b1; sc_clr = 1'b1;
    @(negedge clk); start = 1'b0; sc_clr = 1'b0;
    n_cmp++;
    if ({T, halted} !== {8'h00, 1'b1}) begin
      n_err++; $display("FAIL prio_halted: T=%h halted=%b want 00 1", T, halted);
    end
    @(negedge clk);
    n_cmp++;
    if ({T, halted} !== {8'h00, 1'b1}) begin
      n_err++; $display("FAIL prio_stays: T=%h halted=%b want 00 1", T, halted);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (T !== 8'h01) begin n_err++; $display("FAIL prio_restart: T=%h want 01", T); end
  endtask

  task test_reset_mid;
    @(negedge clk);
    ir_ld = 1'b1; bus_in = 16'h3456;
    @(negedge clk); ir_ld = 1'b0;
    n_cmp++;
    if ({ir_q, D, I} !== {16'h3456, 8'h08, 1'b0}) begin
      n_err++; $display("FAIL rmid_load: ir_q=%h D=%h I=%b want 3456 08 0", ir_q, D, I);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (T !== 8'h10) begin n_err++; $display("FAIL rmid_t4: T=%h want 10", T); end
    rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    n_cmp++;
    if ({T, ir_q, halted, D} !== {8'h00, 16'h0000, 1'b1, 8'h01}) begin
      n_err++; $display("FAIL rmid_after: T=%h ir_q=%h halted=%b D=%h want 00 0000 1 01", T, ir_q, halted, D);
    end
    @(negedge clk);
    n_cmp++;
    if ({T, halted} !== {8'h00, 1'b1}) begin
      n_err++; $display("FAIL rmid_stays: T=%h halted=%b want 00 1", T, halted);
    end
  endtask

`ifdef MANO_SINGLE_STEP_EN
  task test_single_step;
    for (int r = 0; r < 2; r++) begin
      step = 1'b1;
      @(negedge clk); step = 1'b0;
      n_cmp++;
      if ({T, halted} !== {8'h01, 1'b0}) begin
        n_err++; $display("FAIL step%0d_t0: T=%h halted=%b want 01 0", r, T, halted);
      end
      @(negedge clk);
      ir_ld = 1'b1; bus_in = 16'h7020;
      @(negedge clk); ir_ld = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (T !== 8'h08) begin n_err++; $display("FAIL step%0d_t3: T=%h want 08", r, T); end
      sc_clr = 1'b1;
      @(negedge clk); sc_clr = 1'b0;
      n_cmp++;
      if ({T, halted} !== {8'h00, 1'b1}) begin
        n_err++; $display("FAIL step%0d_end: T=%h halted=%b want 00 1", r, T, halted);
      end
      @(negedge clk);
      n_cmp++;
      if ({T, halted} !== {8'h00, 1'b1}) begin
        n_err++; $display("FAIL step%0d_stays: T=%h halted=%b want 00 1", r, T, halted);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_decode();
    test_halt();
    test_wrap();
    test_hlt_priority();
    test_reset_mid();
`ifdef MANO_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
